// File: rtl/nnspc_loader.sv
// Frames a parallel config word into a clear pulse plus LSB-first serial load, optionally sweeping NSEL 0..max.
// Latency: CLR one cycle after Start acceptance, WORD_W shift cycles, then DONE. Start is ignored while Busy.
module nnspc_loader #(
    parameter int WORD_W  = 10,
    parameter int NSEL_W  = 5,
    parameter int DWELL_W = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Sweep,
    input  logic [WORD_W-1:0]   Word_in,
    input  logic [DWELL_W-1:0]  Dwell,
    output logic                Busy,
    output logic                Done,
    output logic                Cfg_out,
    output logic                Spc_resetn,
    output logic [NSEL_W-1:0]   Nsel_cur
);

    localparam int BC_W = $clog2(WORD_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DWELL,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [WORD_W-1:0]    shadow_q;
    logic                 sweep_q;
    logic [DWELL_W-1:0]   dwell_q;
    logic [BC_W-1:0]      bit_cnt_q;
    logic [DWELL_W-1:0]   dwell_cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 cfg_out_q;
    logic                 spc_resetn_q;

    logic [BC_W-1:0]      bit_cnt_d;
    logic [NSEL_W-1:0]    nsel_d;
    logic                 dwell_last;
    logic                 nsel_last;

    always_comb begin
        bit_cnt_d  = bit_cnt_q + 1'b1;
        nsel_d     = shadow_q[WORD_W-1 -: NSEL_W] + 1'b1;
        nsel_last  = &shadow_q[WORD_W-1 -: NSEL_W];
        // A zero dwell still spends one cycle in DWELL
        dwell_last = (dwell_q == '0) || (dwell_cnt_q == dwell_q - 1'b1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            shadow_q     <= '0;
            sweep_q      <= 1'b0;
            dwell_q      <= '0;
            bit_cnt_q    <= '0;
            dwell_cnt_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_out_q    <= 1'b0;
            spc_resetn_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    cfg_out_q    <= 1'b0;
                    spc_resetn_q <= 1'b1;
                    if (Start) begin
                        shadow_q     <= Sweep ? {{NSEL_W{1'b0}}, Word_in[WORD_W-NSEL_W-1:0]}
                                              : Word_in;
                        sweep_q      <= Sweep;
                        dwell_q      <= Dwell;
                        bit_cnt_q    <= '0;
                        busy_q       <= 1'b1;
                        spc_resetn_q <= 1'b0;
                        state_q      <= S_CLR;
                    end
                end
                S_CLR: begin
                    spc_resetn_q <= 1'b1;
                    cfg_out_q    <= shadow_q[0];
                    bit_cnt_q    <= '0;
                    state_q      <= S_SHIFT;
                end
                S_SHIFT: begin
                    // bit_cnt_q names the bit currently on Cfg_out
                    if (bit_cnt_q == BC_W'(WORD_W - 1)) begin
                        cfg_out_q   <= 1'b0;
                        dwell_cnt_q <= '0;
                        if (sweep_q) begin
                            state_q <= S_DWELL;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_d;
                        cfg_out_q <= shadow_q[bit_cnt_d];
                    end
                end
                S_DWELL: begin
                    if (dwell_last) begin
                        if (nsel_last) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            shadow_q[WORD_W-1 -: NSEL_W] <= nsel_d;
                            spc_resetn_q <= 1'b0;
                            bit_cnt_q    <= '0;
                            state_q      <= S_CLR;
                        end
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    cfg_out_q    <= 1'b0;
                    spc_resetn_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Cfg_out    = cfg_out_q;
    assign Spc_resetn = spc_resetn_q;
    assign Nsel_cur   = shadow_q[WORD_W-1 -: NSEL_W];

endmodule
